bus_xbar_rr: RTL
================

Name: bus_xbar_rr

Overview:
- Next-generation N-host × M-device crossbar for the Ibex-style req/gnt/rvalid bus in the SoC interconnect.
- Adds per-device round-robin arbitration, device-side backpressure (device_gnt_i) and multiple outstanding transactions per host.
- Routes in-order responses back to the issuing host; unmapped addresses get an error response.
- Sits between the core instruction/data ports plus the debug host and the peripheral set: memory, GPIO, PWM, UART, timer, SPI, sim-ctrl, Wishbone master, debug.

Parameters:
- NrHosts, 2, number of host ports (≥1).
- NrDevices, 8, number of device ports (≥1).
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.
- MaxOutstanding, 2, per-host outstanding limit and per-device route-FIFO depth (≥1).
- DevBase, all zeros, packed NrDevices×AddressWidth base addresses.
- DevMask, all zeros, packed NrDevices×AddressWidth masks.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- host_req_i  in  NrHosts  request.
- host_gnt_o  out  NrHosts  request accepted this cycle.
- host_addr_i  in  NrHosts×AddressWidth  address.
- host_we_i  in  NrHosts  write enable.
- host_be_i  in  NrHosts×DataWidth/8  byte enables.
- host_wdata_i  in  NrHosts×DataWidth  write data.
- host_rvalid_o  out  NrHosts  response valid.
- host_rdata_o  out  NrHosts×DataWidth  read data.
- host_err_o  out  NrHosts  error response.
- device_req_o  out  NrDevices  request.
- device_gnt_i  in  NrDevices  device accepts request.
- device_addr_o  out  NrDevices×AddressWidth  address.
- device_we_o  out  NrDevices  write enable.
- device_be_o  out  NrDevices×DataWidth/8  byte enables.
- device_wdata_o  out  NrDevices×DataWidth  write data.
- device_rvalid_i  in  NrDevices  response valid.
- device_rdata_i  in  NrDevices×DataWidth  read data.
- device_err_i  in  NrDevices  device error.

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous, active-high.
- Decode:
  - Host h targets device d when (addr & DevMask[d]) == DevBase[d]; lowest d wins on overlap.
  - No match targets the internal miss slot (index NrDevices).
- Host eligibility: request eligible iff outstanding count < MaxOutstanding AND (count == 0 OR target == last target). This forbids cross-device reordering.
- Arbitration (per device):
  - Round-robin among eligible requesting hosts, starting at rr_ptr[d].
  - device_req_o[d] = winner exists AND route FIFO[d] not full.
  - Request fields are muxed from the winner, combinationally.
  - host_gnt_o[winner] = device_req_o[d] & device_gnt_i[d], same cycle.
  - On an accepted transfer: rr_ptr[d] ← winner+1 mod NrHosts; push winner ID into route FIFO[d].
- Miss slot:
  - Always grants the eligible round-robin winner.
  - Response is asserted exactly 1 cycle later: rvalid=1, err=1, rdata=0.
- Responses:
  - Devices respond in order, ≥1 cycle after gnt.
  - device_rvalid_i[d] pops FIFO[d]; host_rvalid_o/rdata/err drive the popped host combinationally, same cycle.
  - Because of the single-target rule, at most one source responds per host per cycle.
  - device_rvalid_i with FIFO empty is dropped silently.
- Outstanding counter (per host):
  - +1 on gnt, −1 on rvalid; both in the same cycle leave it unchanged.
  - Target register updates on gnt.
- Boundaries:
  - FIFO full: no request issued to that device.
  - Count == MaxOutstanding: host stalls.
  - A host requesting a different device while transactions are outstanding waits until its count reaches 0.
  - Simultaneous FIFO push and pop is allowed when full.
- Reset (also applied mid-operation): all outputs 0, rr_ptr 0, FIFOs empty, counters 0. In-flight responses arriving after reset are dropped.
- Latency: zero-cycle request path; zero-cycle response path; miss response 1 cycle.

Optional Feature:
- Macro: BUS_XBAR_STALL_CNT_EN.
- Defined:
  - Adds port host_stall_cnt_o (out, NrHosts×32).
  - Per host, a saturating counter increments each cycle host_req_i=1 and host_gnt_o=0.
  - Resets to 0; holds at 0xFFFFFFFF.
- Undefined: the port and the counters do not exist; all other behaviour is identical.

Decomposition:
- Package bus_xbar_pkg:
  - host-ID width function (clog2, minimum 1);
  - device-index type sized NrDevices+1 (includes the miss slot);
  - response struct {rvalid, rdata, err}.
- Sub-module bus_xbar_rr_arb: one-hot round-robin arbiter with pointer register, instanced once per device plus once for the miss slot.
- Route FIFOs use a small inline pointer-based FIFO.

Test Plan:
- Single host reads device 1 (GPIO base), device_gnt_i=1, rvalid 2 cycles later with rdata=0xA5A5A5A5 → host 0 gets gnt same cycle, rvalid=1 with 0xA5A5A5A5, err=0.
- Hosts 0 and 1 both request device 0 continuously for 4 cycles → grants alternate 0,1,0,1; device_req_o never drops.
- Host 0 address 0xDEAD0000 (unmapped) → gnt same cycle; rvalid=1, err=1, rdata=0 next cycle.
- MaxOutstanding=2, device withholds rvalid → host gets 2 gnts, then host_gnt_o=0 until the first rvalid; the third gnt follows in that same cycle.
- Host 0 has 1 outstanding to device 0 and requests device 3 → no gnt until the response returns; then gnt on device 3.
- Assert rst_i with 2 outstanding, then device_rvalid_i=1 after release → no host_rvalid_o; counters 0.

Source files
------------

// File: rtl/bus_xbar_pkg.sv
// Shared types and helpers for the round-robin bus crossbar.
// Optional feature macro used by the top: BUS_XBAR_STALL_CNT_EN.
package bus_xbar_pkg;

   localparam int unsigned XBAR_DW         = 32;
   localparam int unsigned XBAR_NR_DEVICES = 8;

   // Width of a host identifier: clog2(n), never below one bit
   function automatic int unsigned host_id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a device index including the internal miss slot
   function automatic int unsigned dev_idx_w(input int unsigned nr_dev);
      return host_id_w(nr_dev + 1);
   endfunction

   typedef logic [dev_idx_w(XBAR_NR_DEVICES)-1:0] dev_idx_t;

   typedef struct packed {
      logic               rvalid;
      logic [XBAR_DW-1:0] rdata;
      logic               err;
   } rsp_t;

endpackage

// File: rtl/bus_xbar_rr_arb.sv
// One-hot round-robin arbiter; the pointer moves past the winner on advance.
module bus_xbar_rr_arb #(
   parameter int unsigned N    = 2,
   parameter int unsigned IdxW = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [N-1:0]    i_req,
   input  logic            i_advance,
   output logic [N-1:0]    o_gnt_c,
   output logic [IdxW-1:0] o_idx_c,
   output logic            o_valid_c
);

   logic [IdxW-1:0] r_ptr;
   logic [IdxW-1:0] w_cand;

   // Pick the first requester at or after the pointer
   always_comb begin
      o_gnt_c   = '0;
      o_idx_c   = '0;
      o_valid_c = 1'b0;
      w_cand    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_cand = IdxW'((32'(r_ptr) + k) % N);
         if (!o_valid_c && i_req[w_cand]) begin
            o_valid_c       = 1'b1;
            o_idx_c         = w_cand;
            o_gnt_c[w_cand] = 1'b1;
         end
      end
   end

   // Pointer advances to winner+1 on an accepted transfer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_advance && o_valid_c) begin
         r_ptr <= (o_idx_c == IdxW'(N - 1)) ? '0 : o_idx_c + IdxW'(1);
      end
   end

endmodule

// File: rtl/bus_xbar_rr.sv
// N-host x M-device req/gnt/rvalid crossbar with per-device round-robin,
// in-order response routing and an error-responding miss slot.
// Optional: BUS_XBAR_STALL_CNT_EN adds per-host saturating stall counters.
module bus_xbar_rr
   import bus_xbar_pkg::*;
#(
   parameter int unsigned NrHosts        = 2,
   parameter int unsigned NrDevices      = 8,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddressWidth   = 32,
   parameter int unsigned MaxOutstanding = 2,
   parameter logic [NrDevices*AddressWidth-1:0] DevBase = '0,
   parameter logic [NrDevices*AddressWidth-1:0] DevMask = '0
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NrHosts-1:0]                host_req_i,
   output logic [NrHosts-1:0]                host_gnt_o,
   input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]                host_we_i,
   input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
   input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
   output logic [NrHosts-1:0]                host_rvalid_o,
   output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
   output logic [NrHosts-1:0]                host_err_o,
   output logic [NrDevices-1:0]              device_req_o,
   input  logic [NrDevices-1:0]              device_gnt_i,
   output logic [NrDevices*AddressWidth-1:0] device_addr_o,
   output logic [NrDevices-1:0]              device_we_o,
   output logic [NrDevices*DataWidth/8-1:0]  device_be_o,
   output logic [NrDevices*DataWidth-1:0]    device_wdata_o,
   input  logic [NrDevices-1:0]              device_rvalid_i,
   input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
   input  logic [NrDevices-1:0]              device_err_i
`ifdef BUS_XBAR_STALL_CNT_EN
   ,
   output logic [NrHosts*32-1:0]             host_stall_cnt_o
`endif
);

   localparam int unsigned AW      = AddressWidth;
   localparam int unsigned BeW     = DataWidth / 8;
   localparam int unsigned NrSlots = NrDevices + 1;
   localparam int unsigned HidW    = host_id_w(NrHosts);
   localparam int unsigned DevIdxW = dev_idx_w(NrDevices);
   localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
   localparam int unsigned FptrW   = host_id_w(MaxOutstanding);

   logic [DevIdxW-1:0] w_tgt     [NrHosts];
   logic [DevIdxW-1:0] r_last    [NrHosts];
   logic [CntW-1:0]    r_cnt     [NrHosts];
   logic [CntW-1:0]    w_cnt_eff [NrHosts];
   logic [NrHosts-1:0] w_elig;

   logic [NrHosts-1:0] w_slot_req [NrSlots];
   logic [NrHosts-1:0] w_slot_gnt [NrSlots];
   logic [HidW-1:0]    w_slot_idx [NrSlots];
   logic               w_slot_vld [NrSlots];
   logic [NrSlots-1:0] w_slot_acc;

   logic [HidW-1:0]    r_fifo [NrDevices][MaxOutstanding];
   logic [FptrW-1:0]   r_wptr [NrDevices];
   logic [FptrW-1:0]   r_rptr [NrDevices];
   logic [CntW-1:0]    r_fcnt [NrDevices];
   logic [HidW-1:0]    w_head [NrDevices];
   logic [NrDevices-1:0] w_pop;
   logic [NrDevices-1:0] w_full;

   rsp_t               r_miss;
   logic [HidW-1:0]    r_miss_hid;

   function automatic logic [FptrW-1:0] ptr_inc(input logic [FptrW-1:0] p);
      return (p == FptrW'(MaxOutstanding - 1)) ? '0 : p + FptrW'(1);
   endfunction

   // Address decode; lowest matching device wins, no match selects the miss slot
   always_comb begin
      for (int h = 0; h < NrHosts; h++) begin
         w_tgt[h] = DevIdxW'(NrDevices);
         for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
            if ((host_addr_i[h*AW +: AW] & DevMask[d*AW +: AW]) == DevBase[d*AW +: AW]) begin
               w_tgt[h] = DevIdxW'(d);
            end
         end
      end
   end

   // Route FIFO heads and pops; responses with no pending entry are dropped
   always_comb begin
      w_pop = '0;
      for (int d = 0; d < NrDevices; d++) begin
         w_head[d] = r_fifo[d][r_rptr[d]];
         w_pop[d]  = device_rvalid_i[d] && (r_fcnt[d] != '0) && !rst_i;
      end
   end

   // Steer popped device responses and the miss response to their hosts
   always_comb begin
      host_rvalid_o = '0;
      host_rdata_o  = '0;
      host_err_o    = '0;
      for (int h = 0; h < NrHosts; h++) begin
         for (int d = 0; d < NrDevices; d++) begin
            if (w_pop[d] && (w_head[d] == HidW'(h))) begin
               host_rvalid_o[h]                     = 1'b1;
               host_rdata_o[h*DataWidth +: DataWidth] = device_rdata_i[d*DataWidth +: DataWidth];
               host_err_o[h]                        = device_err_i[d];
            end
         end
         if (r_miss.rvalid && !rst_i && (r_miss_hid == HidW'(h))) begin
            host_rvalid_o[h]                     = 1'b1;
            host_rdata_o[h*DataWidth +: DataWidth] = DataWidth'(r_miss.rdata);
            host_err_o[h]                        = r_miss.err;
         end
      end
   end

   // Eligibility counts a same-cycle response as already retired
   always_comb begin
      w_elig = '0;
      for (int h = 0; h < NrHosts; h++) begin
         w_cnt_eff[h] = r_cnt[h] - CntW'(host_rvalid_o[h]);
         w_elig[h]    = host_req_i[h] && !rst_i &&
                        (w_cnt_eff[h] < CntW'(MaxOutstanding)) &&
                        ((w_cnt_eff[h] == '0) || (w_tgt[h] == r_last[h]));
      end
      for (int s = 0; s < NrSlots; s++) begin
         w_slot_req[s] = '0;
         for (int h = 0; h < NrHosts; h++) begin
            w_slot_req[s][h] = w_elig[h] && (w_tgt[h] == DevIdxW'(s));
         end
      end
   end

   for (genvar s = 0; s < NrSlots; s++) begin : g_arb
      bus_xbar_rr_arb #(
         .N    (NrHosts),
         .IdxW (HidW)
      ) u_arb (
         .i_clk     (clk_i),
         .i_rst     (rst_i),
         .i_req     (w_slot_req[s]),
         .i_advance (w_slot_acc[s]),
         .o_gnt_c   (w_slot_gnt[s]),
         .o_idx_c   (w_slot_idx[s]),
         .o_valid_c (w_slot_vld[s])
      );
   end

   // Device request issue and winner field mux; miss slot always accepts
   always_comb begin
      device_req_o   = '0;
      device_addr_o  = '0;
      device_we_o    = '0;
      device_be_o    = '0;
      device_wdata_o = '0;
      w_full         = '0;
      w_slot_acc     = '0;
      for (int d = 0; d < NrDevices; d++) begin
         w_full[d]       = (r_fcnt[d] == CntW'(MaxOutstanding)) && !w_pop[d];
         device_req_o[d] = w_slot_vld[d] && !w_full[d];
         w_slot_acc[d]   = device_req_o[d] && device_gnt_i[d];
         for (int h = 0; h < NrHosts; h++) begin
            if (w_slot_gnt[d][h]) begin
               device_addr_o[d*AW +: AW]               = host_addr_i[h*AW +: AW];
               device_we_o[d]                          = host_we_i[h];
               device_be_o[d*BeW +: BeW]               = host_be_i[h*BeW +: BeW];
               device_wdata_o[d*DataWidth +: DataWidth] = host_wdata_i[h*DataWidth +: DataWidth];
            end
         end
      end
      w_slot_acc[NrDevices] = w_slot_vld[NrDevices];
   end

   // Host grant when its slot accepted the transfer
   always_comb begin
      host_gnt_o = '0;
      for (int s = 0; s < NrSlots; s++) begin
         for (int h = 0; h < NrHosts; h++) begin
            if (w_slot_gnt[s][h] && w_slot_acc[s]) host_gnt_o[h] = 1'b1;
         end
      end
   end

   // Per-host outstanding count and last target
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int h = 0; h < NrHosts; h++) begin
            r_cnt[h]  <= '0;
            r_last[h] <= '0;
         end
      end else begin
         for (int h = 0; h < NrHosts; h++) begin
            r_cnt[h] <= r_cnt[h] + CntW'(host_gnt_o[h]) - CntW'(host_rvalid_o[h]);
            if (host_gnt_o[h]) r_last[h] <= w_tgt[h];
         end
      end
   end

   // Per-device route FIFOs holding the issuing host of each transfer
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int d = 0; d < NrDevices; d++) begin
            r_wptr[d] <= '0;
            r_rptr[d] <= '0;
            r_fcnt[d] <= '0;
            for (int i = 0; i < MaxOutstanding; i++) r_fifo[d][i] <= '0;
         end
      end else begin
         for (int d = 0; d < NrDevices; d++) begin
            if (w_slot_acc[d]) begin
               r_fifo[d][r_wptr[d]] <= w_slot_idx[d];
               r_wptr[d]            <= ptr_inc(r_wptr[d]);
            end
            if (w_pop[d]) r_rptr[d] <= ptr_inc(r_rptr[d]);
            r_fcnt[d] <= r_fcnt[d] + CntW'(w_slot_acc[d]) - CntW'(w_pop[d]);
         end
      end
   end

   // Miss slot answers one cycle after the grant with an error
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_miss     <= '0;
         r_miss_hid <= '0;
      end else begin
         r_miss     <= rsp_t'{rvalid: w_slot_acc[NrDevices], rdata: '0, err: w_slot_acc[NrDevices]};
         r_miss_hid <= w_slot_idx[NrDevices];
      end
   end

`ifdef BUS_XBAR_STALL_CNT_EN
   logic [31:0] r_stall [NrHosts];

   // Saturating count of cycles a host requested without a grant
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int h = 0; h < NrHosts; h++) r_stall[h] <= '0;
      end else begin
         for (int h = 0; h < NrHosts; h++) begin
            if (host_req_i[h] && !host_gnt_o[h] && (r_stall[h] != 32'hFFFF_FFFF)) begin
               r_stall[h] <= r_stall[h] + 32'd1;
            end
         end
      end
   end

   // Flatten stall counters onto the output port
   always_comb begin
      host_stall_cnt_o = '0;
      for (int h = 0; h < NrHosts; h++) host_stall_cnt_o[h*32 +: 32] = r_stall[h];
   end
`endif

endmodule
